// File: rtl/mem_access_unit.sv
// Sub-word load/store sequencer between execute stage and a word-wide data RAM.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses complete at once with err_o.
module mem_access_unit #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] wdat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdat_o,
  output logic        err_o,
  output logic        ram_wen_o,
  output logic [31:0] ram_adr_o,
  output logic [31:0] ram_dat_o,
  input  logic [31:0] ram_dat_i
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  // Store codes 100/101 are not sub-word stores, so they fall back to word.
  function automatic size_e access_size(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000:  return SZ_BYTE;
      3'b001:  return SZ_HALF;
      3'b100:  return we ? SZ_WORD : SZ_BYTE;
      3'b101:  return we ? SZ_WORD : SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input size_e sz, input logic uns,
                                               input logic [1:0] lane, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: return {{24{b[7] & ~uns}}, b};
      SZ_HALF: return {{16{h[15] & ~uns}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input size_e sz, input logic [1:0] lane,
                                              input logic [31:0] old, input logic [15:0] wd);
    logic [31:0] w;
    w = old;
    case (sz)
      SZ_BYTE: w[8*lane +: 8]     = wd[7:0];
      SZ_HALF: w[16*lane[1] +: 16] = wd;
      default: w = old;
    endcase
    return w;
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic misaligned(input size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction
`endif

  state_e      state_q, state_d;
  size_e       sz_q, sz_d, req_sz;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdat_q, wdat_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdat_q, rdat_d;
  logic [31:0] ram_adr_q, ram_adr_d;
  logic [31:0] ram_dat_q, ram_dat_d;
`ifdef MISALIGN_TRAP_EN
  logic        err_q, err_d;
`endif

  assign req_sz = access_size(we_i, funct3_i);

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d   = state_q;
    sz_d      = sz_q;
    we_d      = we_q;
    uns_d     = uns_q;
    lane_d    = lane_q;
    wdat_d    = wdat_q;
    cnt_d     = cnt_q;
    rdat_d    = rdat_q;
    ram_adr_d = ram_adr_q;
    ram_dat_d = ram_dat_q;
`ifdef MISALIGN_TRAP_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d      = we_i;
          sz_d      = req_sz;
          uns_d     = funct3_i[2];
          lane_d    = adr_i[1:0];
          wdat_d    = wdat_i[15:0];
          cnt_d     = 2'd0;
          ram_adr_d = {adr_i[31:2], 2'b00};
          if (we_i && req_sz == SZ_WORD) begin
            ram_dat_d = wdat_i;
            state_d   = S_WRITE;
          end else begin
            state_d   = S_READ;
          end
`ifdef MISALIGN_TRAP_EN
          // A trapped access must leave the RAM bus untouched.
          if (misaligned(req_sz, adr_i[1:0])) begin
            ram_adr_d = ram_adr_q;
            ram_dat_d = ram_dat_q;
            err_d     = 1'b1;
            state_d   = S_RESP;
          end
`endif
        end
      end
      S_READ: begin
        if (cnt_q == CNT_LAST) begin
          if (we_q) begin
            ram_dat_d = store_merge(sz_q, lane_q, ram_dat_i, wdat_q);
            state_d   = S_WRITE;
          end else begin
            rdat_d    = load_extract(sz_q, uns_q, lane_q, ram_dat_i);
            state_d   = S_RESP;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i) begin
    // NOTE: all registers (including captured request fields) are reset so
    // nothing carries X-state or stale data out of a mid-operation reset.
    if (rst_i) begin
      state_q   <= S_IDLE;
      sz_q      <= SZ_BYTE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      lane_q    <= 2'd0;
      wdat_q    <= 16'd0;
      cnt_q     <= 2'd0;
      rdat_q    <= 32'd0;
      ram_adr_q <= 32'd0;
      ram_dat_q <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sz_q      <= sz_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      lane_q    <= lane_d;
      wdat_q    <= wdat_d;
      cnt_q     <= cnt_d;
      rdat_q    <= rdat_d;
      ram_adr_q <= ram_adr_d;
      ram_dat_q <= ram_dat_d;
`ifdef MISALIGN_TRAP_EN
      err_q     <= err_d;
`endif
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_RESP);
  assign ram_wen_o = (state_q == S_WRITE);
  assign rdat_o    = rdat_q;
  assign ram_adr_o = ram_adr_q;
  assign ram_dat_o = ram_dat_q;
`ifdef MISALIGN_TRAP_EN
  assign err_o     = err_q;
`else
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus scoreboard queues
// for RAM writes and completions, and hand sequences for reset/busy corners.
module tb_mem_access_unit;

  localparam int RD_LAT = 1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] adr_i = 32'd0;
  logic [31:0] wdat_i = 32'd0;
  logic        busy_o, done_o, err_o, ram_wen_o;
  logic [31:0] rdat_o, ram_adr_o, ram_dat_o, ram_dat_i;

  mem_access_unit #(.RD_LAT(RD_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .adr_i(adr_i), .wdat_i(wdat_i), .busy_o(busy_o), .done_o(done_o), .rdat_o(rdat_o),
    .err_o(err_o), .ram_wen_o(ram_wen_o), .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o),
    .ram_dat_i(ram_dat_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM model; the address is held through READ, so a combinational read
  // satisfies any read latency.
  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_dat = 32'd0;
  always @(posedge clk_i) begin
    if (pre_en) mem[pre_idx] <= pre_dat;
    else if (ram_wen_o) mem[ram_adr_o[7:2]] <= ram_dat_o;
  end
  assign ram_dat_i = mem[ram_adr_o[7:2]];

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;
  typedef struct {
    logic [31:0] rdat;
    logic        err;
  } resp_t;

  wr_t   exp_wq[$];
  resp_t exp_rq[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    wr_cnt = 0;
  logic [31:0] last_rdat = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Scoreboard side: pop on each RAM write and each completion pulse.
  always @(negedge clk_i) begin
    if (ram_wen_o === 1'b1) begin
      wr_cnt++;
      check("wr_pending", 32'(exp_wq.size() != 0), 32'd1);
      if (exp_wq.size() != 0) begin
        wr_t w;
        w = exp_wq.pop_front();
        check("wr_adr", ram_adr_o, w.adr);
        check("wr_dat", ram_dat_o, w.dat);
      end
    end
    if (done_o === 1'b1) begin
      check("resp_pending", 32'(exp_rq.size() != 0), 32'd1);
      if (exp_rq.size() != 0) begin
        resp_t r;
        r = exp_rq.pop_front();
        check("rdat", rdat_o, r.rdat);
        check("err", 32'(err_o), 32'(r.err));
      end
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] init;
    logic [31:0] exp_rdat;  // load result (ignored for stores / errors)
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;    // 0 or 1 RAM writes
    logic [31:0] exp_wdat;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic we, input logic [2:0] f3,
                              input logic [31:0] adr, input logic [31:0] wdat,
                              input logic [31:0] init, input logic [31:0] er,
                              input logic ee, input int lat, input int nw,
                              input logic [31:0] ew);
    vec_t v;
    v.name = nm; v.we = we; v.f3 = f3; v.adr = adr; v.wdat = wdat; v.init = init;
    v.exp_rdat = er; v.exp_err = ee; v.exp_lat = lat; v.exp_wr = nw; v.exp_wdat = ew;
    return v;
  endfunction

  task automatic preload(input logic [31:0] adr, input logic [31:0] dat);
    pre_idx = adr[7:2];
    pre_dat = dat;
    pre_en  = 1'b1;
    @(posedge clk_i);
    #1 pre_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit hold_req);
    int   wr0, lat;
    bit   seen;
    resp_t r;
    preload(v.adr, v.init);
    if (v.exp_wr != 0) exp_wq.push_back('{adr: {v.adr[31:2], 2'b00}, dat: v.exp_wdat});
    if (!v.we && !v.exp_err) last_rdat = v.exp_rdat;
    r.rdat = last_rdat;
    r.err  = v.exp_err;
    exp_rq.push_back(r);
    wr0 = wr_cnt;
    @(negedge clk_i);
    we_i = v.we; funct3_i = v.f3; adr_i = v.adr; wdat_i = v.wdat; req_i = 1'b1;
    @(posedge clk_i);
    #1 if (!hold_req) req_i = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk_i);
      if (n == 1 && v.exp_lat > 1) check({v.name, "_busy"}, 32'(busy_o), 32'd1);
      if (done_o) begin seen = 1'b1; lat = n; end
    end
    req_i = 1'b0;
    if (!seen) check({v.name, "_done_timeout"}, 32'(done_o), 32'd1);
    else check({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, "_writes"}, 32'(wr_cnt - wr0), 32'(v.exp_wr));
  endtask

  vec_t vecs[$];

  initial begin
    int wr0;
    vecs.push_back(mk("lb_l3",   0, 3'b000, 32'h0000_0103, 0, 32'h80FF_1234, 32'hFFFF_FF80, 0, RD_LAT+1, 0, 0));
    vecs.push_back(mk("lbu_l3",  0, 3'b100, 32'h0000_0103, 0, 32'h80FF_1234, 32'h0000_0080, 0, RD_LAT+1, 0, 0));
    vecs.push_back(mk("lh_h1",   0, 3'b001, 32'h0000_0202, 0, 32'h8001_7FFF, 32'hFFFF_8001, 0, RD_LAT+1, 0, 0));
    vecs.push_back(mk("lhu_h1",  0, 3'b101, 32'h0000_0202, 0, 32'h8001_7FFF, 32'h0000_8001, 0, RD_LAT+1, 0, 0));
    vecs.push_back(mk("sb_l1",   1, 3'b000, 32'h0000_0011, 32'h0000_00AB, 32'h1122_3344, 0, 0, RD_LAT+2, 1, 32'h1122_AB44));
    vecs.push_back(mk("sh_h1",   1, 3'b001, 32'h0000_0022, 32'h1234_CAFE, 32'h1122_3344, 0, 0, RD_LAT+2, 1, 32'hCAFE_3344));
    vecs.push_back(mk("lw",      0, 3'b010, 32'h0000_0044, 0, 32'h89AB_CDEF, 32'h89AB_CDEF, 0, RD_LAT+1, 0, 0));
    vecs.push_back(mk("lb_pos",  0, 3'b000, 32'h0000_0048, 0, 32'h0000_007F, 32'h0000_007F, 0, RD_LAT+1, 0, 0));
    vecs.push_back(mk("lh_h0",   0, 3'b001, 32'h0000_004C, 0, 32'h5555_F00D, 32'hFFFF_F00D, 0, RD_LAT+1, 0, 0));
    vecs.push_back(mk("ld_f011", 0, 3'b011, 32'h0000_0058, 0, 32'h1357_9BDF, 32'h1357_9BDF, 0, RD_LAT+1, 0, 0));
    vecs.push_back(mk("st_f100", 1, 3'b100, 32'h0000_005C, 32'h0F0F_F0F0, 32'h0000_0000, 0, 0, 2, 1, 32'h0F0F_F0F0));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk("lw_mis",  0, 3'b010, 32'h0000_0006, 0, 32'h0123_4567, 0, 1, 1, 0, 0));
    vecs.push_back(mk("sh_mis",  1, 3'b001, 32'h0000_0051, 32'h0000_5A5A, 32'hAAAA_AAAA, 0, 1, 1, 0, 0));
`else
    vecs.push_back(mk("lw_mis",  0, 3'b010, 32'h0000_0006, 0, 32'h0123_4567, 32'h0123_4567, 0, RD_LAT+1, 0, 0));
    vecs.push_back(mk("sh_mis",  1, 3'b001, 32'h0000_0051, 32'h0000_5A5A, 32'hAAAA_AAAA, 0, 0, RD_LAT+2, 1, 32'hAAAA_5A5A));
`endif

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_wen", 32'(ram_wen_o), 0);
    check("rst_rdat", rdat_o, 0);
    check("rst_radr", ram_adr_o, 0);
    check("rst_rdat_o", ram_dat_o, 0);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], 1'b0);

    // sw with req_i held through busy: exactly one access
    wr0 = wr_cnt;
    run_vec(mk("sw_hold", 1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 0, 0, 2, 1, 32'hDEAD_BEEF), 1'b1);
    repeat (3) @(negedge clk_i);
    check("sw_hold_total_writes", 32'(wr_cnt - wr0), 32'd1);
    check("sw_hold_idle", 32'(busy_o), 0);

    // Reset during READ of sh: no write, all outputs cleared
    preload(32'h0000_0030, 32'h7777_7777);
    wr0 = wr_cnt;
    @(negedge clk_i);
    we_i = 1'b1; funct3_i = 3'b001; adr_i = 32'h0000_0032; wdat_i = 32'h0000_1111; req_i = 1'b1;
    @(posedge clk_i);
    #1 begin req_i = 1'b0; rst_i = 1'b1; end
    @(posedge clk_i);
    @(negedge clk_i);
    check("rr_busy", 32'(busy_o), 0);
    check("rr_wen", 32'(ram_wen_o), 0);
    check("rr_rdat", rdat_o, 0);
    check("rr_radr", ram_adr_o, 0);
    check("rr_rdat_o", ram_dat_o, 0);
    check("rr_no_write", 32'(wr_cnt - wr0), 0);
    last_rdat = 32'd0;
    rst_i = 1'b0;
    run_vec(mk("after_rst", 0, 3'b010, 32'h0000_0030, 0, 32'h7777_7777, 32'h7777_7777, 0, RD_LAT+1, 0, 0), 1'b0);

    // Reset during WRITE of sw: the write cycle is not extended
    preload(32'h0000_0060, 32'h0);
    exp_wq.push_back('{adr: 32'h0000_0060, dat: 32'hA5A5_5A5A});
    wr0 = wr_cnt;
    @(negedge clk_i);
    we_i = 1'b1; funct3_i = 3'b010; adr_i = 32'h0000_0060; wdat_i = 32'hA5A5_5A5A; req_i = 1'b1;
    @(posedge clk_i);
    #1 begin req_i = 1'b0; rst_i = 1'b1; end
    @(posedge clk_i);
    @(negedge clk_i);
    check("rw_wen_off", 32'(ram_wen_o), 0);
    check("rw_one_write", 32'(wr_cnt - wr0), 32'd1);
    last_rdat = 32'd0;

    // Reset and req on the same edge: request dropped
    wr0 = wr_cnt;
    we_i = 1'b1; funct3_i = 3'b010; adr_i = 32'h0000_0064; wdat_i = 32'h1; req_i = 1'b1;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rq_dropped_busy", 32'(busy_o), 0);
    check("rq_dropped_write", 32'(wr_cnt - wr0), 0);

    check("wq_drained", 32'(exp_wq.size()), 0);
    check("rq_drained", 32'(exp_rq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d/%0d checks", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
